ntt_host_seq: RTL and testbench

- Host-side initiator for the NTT polynomial multiplier. Implements the opposite end of the multiplier's load/start/readout interface.
- On go: streams f, then g, from a source memory into the multiplier; pulses start; waits for valid; reads the 2*PC-1 product coefficients and writes them to a result memory.
- Sits between system memory and the NTT core in the test/integration harness.

---
 rtl/ntt_host_seq.sv | 174 +++++++++++++++++
 tb/tb_ntt_host_seq.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_host_seq.sv
// Host-side sequencer for the NTT polynomial multiplier: streams f and g into the
// core, pulses start, waits for the product and copies it into the result memory.
module ntt_host_seq #(
    parameter int P       = 761,
    parameter int Q       = 4591,
    parameter int PC      = 768,
    parameter int GAP     = 8,
    parameter int RD_LAT  = 6,
    parameter int TIMEOUT = 1048576,
    localparam int LG2_Q  = $clog2(Q),
    localparam int LG2_PC = $clog2(PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [LG2_PC:0]   src_addr,
    output logic              src_sel,
    input  logic [LG2_Q-1:0]  src_rdata,
    output logic              ntt_start,
    output logic              ntt_input_fg,
    output logic [LG2_PC:0]   ntt_addr,
    output logic [LG2_Q-1:0]  ntt_din,
    input  logic [LG2_Q-1:0]  ntt_dout,
    input  logic              ntt_valid,
    output logic              res_we,
    output logic [LG2_PC:0]   res_addr,
    output logic [LG2_Q-1:0]  res_wdata
);
    localparam int NW = 2 * PC - 1;
    localparam int AW = LG2_PC + 1;
    localparam int SW = $clog2((GAP > RD_LAT ? GAP : RD_LAT) + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] LAST = AW'(NW - 1);

    typedef enum logic [3:0] {
        IDLE, LOAD_F, GAP_F, LOAD_G, GAP_G, START, WAIT, SETTLE, READ, DRAIN, FIN
    } state_t;

    state_t                     state;
    logic [SW-1:0]              scnt;
    logic [TW-1:0]              wcnt;
    logic                       ld_vld;
    logic [AW-1:0]              ld_addr;
    logic [RD_LAT-1:0]          vld_pipe;
    logic [RD_LAT-1:0][AW-1:0]  addr_pipe;

    if (P > PC) begin : g_p_check
        $error("P must not exceed PC");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            scnt         <= '0;
            wcnt         <= '0;
            ld_vld       <= 1'b0;
            ld_addr      <= '0;
            vld_pipe     <= '0;
            addr_pipe    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            src_addr     <= '0;
            src_sel      <= 1'b0;
            ntt_start    <= 1'b0;
            ntt_input_fg <= 1'b0;
            ntt_addr     <= '0;
            ntt_din      <= '0;
            res_we       <= 1'b0;
            res_addr     <= '0;
            res_wdata    <= '0;
        end else begin
            done      <= 1'b0;
            ntt_start <= 1'b0;
            ld_vld    <= 1'b0;
            // Load words reach the core two cycles after their source address.
            ntt_addr  <= ld_vld ? ld_addr : '0;
            ntt_din   <= ld_vld ? src_rdata : '0;

            for (int i = RD_LAT - 1; i > 0; i--) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
            vld_pipe[0]  <= 1'b0;
            addr_pipe[0] <= '0;
            res_we       <= vld_pipe[RD_LAT-1];
            if (vld_pipe[RD_LAT-1]) begin
                res_addr  <= addr_pipe[RD_LAT-1];
                res_wdata <= ntt_dout;
            end

            case (state)
                IDLE: if (go) begin
                    state        <= LOAD_F;
                    busy         <= 1'b1;
                    err          <= 1'b0;
                    src_addr     <= '0;
                    src_sel      <= 1'b0;
                    ntt_input_fg <= 1'b0;
                end
                LOAD_F, LOAD_G: begin
                    ld_vld  <= 1'b1;
                    ld_addr <= src_addr;
                    if (src_addr == LAST) begin
                        state <= (state == LOAD_F) ? GAP_F : GAP_G;
                        scnt  <= '0;
                    end else begin
                        src_addr <= src_addr + 1'b1;
                    end
                end
                GAP_F: if (scnt == SW'(GAP - 1)) begin
                    state        <= LOAD_G;
                    src_addr     <= '0;
                    src_sel      <= 1'b1;
                    ntt_input_fg <= 1'b1;
                end else begin
                    scnt <= scnt + 1'b1;
                end
                GAP_G: if (scnt == SW'(GAP - 1)) begin
                    state     <= START;
                    ntt_start <= 1'b1;
                end else begin
                    scnt <= scnt + 1'b1;
                end
                // wcnt counts cycles elapsed since the start pulse.
                START: begin
                    state <= WAIT;
                    wcnt  <= TW'(1);
                end
                WAIT: if (ntt_valid) begin
                    state        <= SETTLE;
                    ntt_input_fg <= 1'b0;
                end else if (wcnt >= TW'(TIMEOUT - 1)) begin
                    state        <= FIN;
                    err          <= 1'b1;
                    done         <= 1'b1;
                    ntt_input_fg <= 1'b0;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
                SETTLE: begin
                    state    <= READ;
                    ntt_addr <= '0;
                end
                READ: begin
                    vld_pipe[0]  <= 1'b1;
                    addr_pipe[0] <= ntt_addr;
                    if (ntt_addr == LAST) begin
                        state <= DRAIN;
                        scnt  <= '0;
                    end else begin
                        ntt_addr <= ntt_addr + 1'b1;
                    end
                end
                DRAIN: if (scnt == SW'(RD_LAT - 1)) begin
                    state <= FIN;
                    done  <= 1'b1;
                end else begin
                    scnt <= scnt + 1'b1;
                end
                FIN: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    src_addr <= '0;
                    src_sel  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ntt_host_seq.sv
// Directed bench for ntt_host_seq with a registered source memory and a simple core model.
module tb_ntt_host_seq;
    localparam int Q = 4591, PC = 8, GAP = 8, RD_LAT = 6;
    localparam int LQ = $clog2(Q), AW = $clog2(PC) + 1, NW = 2 * PC - 1;
    localparam int VLD_DLY = 50;
    // Cycle offsets relative to the cycle after go is sampled (rel 1 = first LOAD_F cycle).
    localparam int T_FD    = 3;
    localparam int T_GD    = T_FD + NW + GAP;
    localparam int T_START = 2 * (NW + GAP) + 1;
    localparam int T_READ  = T_START + VLD_DLY + 2;
    localparam int T_WE    = T_READ + RD_LAT + 1;
    localparam int T_DONE  = T_READ + NW + RD_LAT;
    localparam int T_TO    = T_START + 20;
    localparam int T_DONE1 = T_START + 1 + 1 + 1 + NW + RD_LAT;
    localparam int VW      = 3 + AW + LQ + 1;

    logic clk = 1'b0, rst = 1'b1, go = 1'b0, mode = 1'b0;
    logic busy, done, err, src_sel, ntt_start, ntt_input_fg, ntt_valid, res_we;
    logic [AW-1:0] src_addr, ntt_addr, res_addr;
    logic [LQ-1:0] src_rdata, ntt_din, ntt_dout, res_wdata;

    logic go_t = 1'b0, valid_t = 1'b0;
    logic busy_t, done_t, err_t, src_sel_t, start_t, fg_t, res_we_t;
    logic [AW-1:0] src_addr_t, ntt_addr_t, res_addr_t;
    logic [LQ-1:0] ntt_din_t, res_wdata_t;
    logic [LQ-1:0] src_rdata_t = '0, dout_t = '0;

    int n_checks = 0, n_fail = 0;
    int since;
    logic [LQ-1:0] dpipe [RD_LAT];

    always #5 clk = ~clk;

    ntt_host_seq #(.Q(Q), .PC(PC), .GAP(GAP), .RD_LAT(RD_LAT), .TIMEOUT(1000)) u_dut (
        .clk(clk), .rst(rst), .go(go), .busy(busy), .done(done), .err(err),
        .src_addr(src_addr), .src_sel(src_sel), .src_rdata(src_rdata),
        .ntt_start(ntt_start), .ntt_input_fg(ntt_input_fg), .ntt_addr(ntt_addr),
        .ntt_din(ntt_din), .ntt_dout(ntt_dout), .ntt_valid(ntt_valid),
        .res_we(res_we), .res_addr(res_addr), .res_wdata(res_wdata));

    ntt_host_seq #(.Q(Q), .PC(PC), .GAP(GAP), .RD_LAT(RD_LAT), .TIMEOUT(20)) u_dut_to (
        .clk(clk), .rst(rst), .go(go_t), .busy(busy_t), .done(done_t), .err(err_t),
        .src_addr(src_addr_t), .src_sel(src_sel_t), .src_rdata(src_rdata_t),
        .ntt_start(start_t), .ntt_input_fg(fg_t), .ntt_addr(ntt_addr_t),
        .ntt_din(ntt_din_t), .ntt_dout(dout_t), .ntt_valid(valid_t),
        .res_we(res_we_t), .res_addr(res_addr_t), .res_wdata(res_wdata_t));

    // Source memory: f[i]=i, g[i]=100+i; mode 1 returns 4590 only at address 14.
    always @(posedge clk) begin
        if (mode) src_rdata <= (src_addr == AW'(14)) ? LQ'(4590) : '0;
        else      src_rdata <= src_sel ? LQ'(100 + int'(src_addr)) : LQ'(int'(src_addr));
    end

    // Core model: valid VLD_DLY cycles after start; dout = addr*3 after RD_LAT cycles.
    always @(posedge clk) begin
        if (rst) since <= 0;
        else if (ntt_start) since <= 1;
        else if (since > 0 && since < 10000) since <= since + 1;
        dpipe[0] <= LQ'(3 * int'(ntt_addr));
        for (int i = 1; i < RD_LAT; i++) dpipe[i] <= dpipe[i-1];
    end
    assign ntt_valid = (since >= VLD_DLY);
    assign ntt_dout  = dpipe[RD_LAT-1];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic test_reset();
        rst = 1'b1; go = 1'b0; go_t = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, err, src_addr, src_sel, ntt_start, ntt_input_fg, ntt_addr, ntt_din,
             res_we, res_addr, res_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b err=%b src_addr=%0d ntt_addr=%0d ntt_din=%0d res_we=%b, all must be 0",
                     busy, done, err, src_addr, ntt_addr, ntt_din, res_we);
        end
        n_checks++;
        if ({busy_t, done_t, err_t, src_addr_t, start_t, res_we_t} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_to: busy=%b done=%b err=%b res_we=%b, all must be 0",
                     busy_t, done_t, err_t, res_we_t);
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, ntt_start, res_we} !== 4'b0) begin
            n_fail++;
            $display("FAIL idle_without_go: busy=%b done=%b start=%b res_we=%b, want 0", busy, done, ntt_start, res_we);
        end
    endtask

    // One full run from IDLE; returns in the IDLE cycle right after done.
    task automatic run_base(input string tag);
        logic [VW-1:0] got, exp;
        logic [AW-1:0] ea;
        logic [LQ-1:0] ed;
        logic ewe, efg, chk_fg;
        int starts, writes;
        starts = 0; writes = 0;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        for (int r = 1; r <= T_DONE + 1; r++) begin
            ea = '0; ed = '0;
            if (r >= T_FD && r < T_FD + NW) begin ea = AW'(r - T_FD); ed = LQ'(r - T_FD); end
            if (r >= T_GD && r < T_GD + NW) begin ea = AW'(r - T_GD); ed = LQ'(100 + r - T_GD); end
            if (r >= T_READ && r < T_READ + NW) ea = AW'(r - T_READ);
            ewe = (r >= T_WE && r <= T_DONE);
            exp = {r <= T_DONE, r == T_DONE, r == T_START, ea, ed, ewe};
            got = {busy, done, ntt_start, ntt_addr, ntt_din, res_we};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s cycle r=%0d {busy,done,start,addr,din,we}: got %h want %h", tag, r, got, exp);
            end
            if (ewe) begin
                n_checks++;
                if ({res_addr, res_wdata} !== {AW'(r - T_WE), LQ'(3 * (r - T_WE))}) begin
                    n_fail++;
                    $display("FAIL %s res_word r=%0d: got addr %0d data %0d want addr %0d data %0d",
                             tag, r, res_addr, res_wdata, r - T_WE, 3 * (r - T_WE));
                end
            end
            if (r >= 1 && r <= NW) begin
                n_checks++;
                if ({src_sel, src_addr} !== {1'b0, AW'(r - 1)}) begin
                    n_fail++;
                    $display("FAIL %s src_f r=%0d: got sel %b addr %0d want sel 0 addr %0d", tag, r, src_sel, src_addr, r - 1);
                end
            end
            if (r >= T_GD - 2 && r < T_GD - 2 + NW) begin
                n_checks++;
                if ({src_sel, src_addr} !== {1'b1, AW'(r - T_GD + 2)}) begin
                    n_fail++;
                    $display("FAIL %s src_g r=%0d: got sel %b addr %0d want sel 1 addr %0d", tag, r, src_sel, src_addr, r - T_GD + 2);
                end
            end
            chk_fg = 1'b0; efg = 1'b0;
            if ((r >= T_FD && r < T_FD + NW) || (r >= T_READ && r < T_READ + NW)) chk_fg = 1'b1;
            if ((r >= T_GD && r < T_GD + NW) || r == T_START) begin chk_fg = 1'b1; efg = 1'b1; end
            if (chk_fg) begin
                n_checks++;
                if (ntt_input_fg !== efg) begin
                    n_fail++;
                    $display("FAIL %s input_fg r=%0d: got %b want %b", tag, r, ntt_input_fg, efg);
                end
            end
            starts += int'(ntt_start);
            writes += int'(res_we);
            if (r <= T_DONE) begin @(posedge clk); #1; end
        end
        n_checks++;
        if (starts !== 1 || writes !== NW) begin
            n_fail++;
            $display("FAIL %s totals: starts %0d writes %0d want 1 and %0d", tag, starts, writes, NW);
        end
    endtask

    task automatic test_base();
        mode = 1'b0;
        run_base("base");
    endtask

    task automatic test_alignment();
        logic [LQ-1:0] ed;
        mode = 1'b1;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        for (int r = 1; r <= T_DONE + 1; r++) begin
            ed = (r == T_FD + NW - 1 || r == T_GD + NW - 1) ? LQ'(4590) : '0;
            n_checks++;
            if (ntt_din !== ed) begin
                n_fail++;
                $display("FAIL align_din r=%0d: got %0d want %0d", r, ntt_din, ed);
            end
            if (ed != '0) begin
                n_checks++;
                if (ntt_addr !== AW'(14)) begin
                    n_fail++;
                    $display("FAIL align_addr r=%0d: got %0d want 14", r, ntt_addr);
                end
            end
            if (r <= T_DONE) begin @(posedge clk); #1; end
        end
        mode = 1'b0;
    endtask

    task automatic test_timeout();
        logic [3:0] got, exp;
        int r, writes;
        valid_t = 1'b0;
        go_t = 1'b1;
        @(posedge clk); #1;
        go_t = 1'b0;
        writes = 0;
        for (int k = 1; k <= T_TO + 1; k++) begin
            exp = {k <= T_TO, k == T_TO, k >= T_TO, 1'b0};
            got = {busy_t, done_t, err_t, res_we_t};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL timeout r=%0d {busy,done,err,we}: got %b want %b", k, got, exp);
            end
            if (k == T_START) begin
                n_checks++;
                if (start_t !== 1'b1) begin
                    n_fail++;
                    $display("FAIL timeout_start r=%0d: got %b want 1", k, start_t);
                end
            end
            if (k <= T_TO) begin @(posedge clk); #1; end
        end
        // Recovery: valid already high, so WAIT lasts one cycle.
        valid_t = 1'b1;
        go_t = 1'b1;
        @(posedge clk); #1;
        go_t = 1'b0;
        n_checks++;
        if (err_t !== 1'b0 || busy_t !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_err_clear: got err %b busy %b want err 0 busy 1", err_t, busy_t);
        end
        r = 1;
        while (r < 400 && done_t !== 1'b1) begin
            writes += int'(res_we_t);
            @(posedge clk); #1;
            r++;
        end
        writes += int'(res_we_t);
        n_checks++;
        if (done_t !== 1'b1 || r != T_DONE1 || writes != NW || err_t !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_recovery: done %b at r=%0d writes %0d err %b want done at r=%0d writes %0d err 0",
                     done_t, r, writes, err_t, T_DONE1, NW);
        end
        @(posedge clk); #1;
        valid_t = 1'b0;
    endtask

    task automatic test_go_held();
        int starts, dones, r;
        starts = 0; dones = 0;
        go = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= T_DONE; k++) begin
            starts += int'(ntt_start);
            dones  += int'(done);
            if (busy !== 1'b1) begin
                n_checks++; n_fail++;
                $display("FAIL go_held_busy r=%0d: got 0 want 1", k);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (starts != 1 || dones != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL go_held_single_run: starts %0d dones %0d busy %b want 1 1 0", starts, dones, busy);
        end
        @(posedge clk); #1;
        go = 1'b0;
        n_checks++;
        if ({busy, src_sel, src_addr} !== {1'b1, 1'b0, AW'(0)}) begin
            n_fail++;
            $display("FAIL go_held_restart: got busy %b sel %b addr %0d want 1 0 0", busy, src_sel, src_addr);
        end
        r = 1;
        while (r < 400 && done !== 1'b1) begin
            @(posedge clk); #1;
            r++;
        end
        n_checks++;
        if (done !== 1'b1 || r != T_DONE) begin
            n_fail++;
            $display("FAIL go_held_second_run: done %b at r=%0d want done at r=%0d", done, r, T_DONE);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_read();
        int r, writes;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        repeat (T_READ + 4 - 1) @(posedge clk);
        #1;
        n_checks++;
        if (ntt_addr !== AW'(4)) begin
            n_fail++;
            $display("FAIL rst_read_point: ntt_addr got %0d want 4", ntt_addr);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if ({busy, done, err, src_addr, src_sel, ntt_start, ntt_input_fg, ntt_addr, ntt_din,
             res_we, res_addr, res_wdata} !== '0) begin
            n_fail++;
            $display("FAIL rst_read_outputs: busy=%b done=%b ntt_addr=%0d res_we=%b res_addr=%0d, all must be 0",
                     busy, done, ntt_addr, res_we, res_addr);
        end
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({busy, done, res_we} !== 3'b0) begin
                n_fail++;
                $display("FAIL rst_read_quiet k=%0d: busy %b done %b we %b want 0", k, busy, done, res_we);
            end
        end
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        r = 1; writes = 0;
        while (r < 400 && done !== 1'b1) begin
            writes += int'(res_we);
            @(posedge clk); #1;
            r++;
        end
        writes += int'(res_we);
        n_checks++;
        if (done !== 1'b1 || r != T_DONE || writes != NW) begin
            n_fail++;
            $display("FAIL rst_read_fresh_run: done %b at r=%0d writes %0d want r=%0d writes %0d",
                     done, r, writes, T_DONE, NW);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        mode = 1'b0;
        run_base("b2b_first");
        run_base("b2b_second");
    endtask

    initial begin
        test_reset();
        test_base();
        test_alignment();
        test_timeout();
        test_go_held();
        test_reset_mid_read();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
